// File: rtl/reset_sequencer.sv
// Staggered multi-domain reset sequencer: holds every domain in reset, then releases them one by one.
// Optional watchdog is built only when RST_SEQ_WDT_EN is defined.
module reset_sequencer #(
  parameter int          NUM_DOMAINS    = 4,
  parameter int          HOLD_CYCLES    = 16,
  parameter int          STAGGER_CYCLES = 8,
  parameter logic [23:0] WDT_TIMEOUT    = 24'd1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  input  logic                   ext_rst_req,
  input  logic                   wdt_kick,
  input  logic                   cause_clear,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   all_released,
  output logic [2:0]             rst_cause
);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] STAG_LAST = 8'(STAGGER_CYCLES - 1);
  localparam logic [2:0] IDX_LAST  = 3'(NUM_DOMAINS - 1);

  state_t                 state, state_nxt;
  logic [7:0]             cnt, cnt_nxt;
  logic [2:0]             idx, idx_nxt;
  logic [NUM_DOMAINS-1:0] dom_nxt;
  logic                   wdt_evt;
  logic                   evt;
  logic [2:0]             cause_now;

`ifdef RST_SEQ_WDT_EN
  localparam logic [23:0] WDT_LAST = WDT_TIMEOUT - 24'd1;
  logic [23:0] wdt_cnt;

  assign wdt_evt = (state == RUN) && (wdt_cnt == WDT_LAST);

  // Runs only in RUN; any departure from RUN (including its own expiry) restarts it.
  always_ff @(posedge clk) begin
    if (rst)
      wdt_cnt <= '0;
    else if (state != RUN || wdt_kick || evt)
      wdt_cnt <= '0;
    else if (wdt_cnt != WDT_LAST)
      wdt_cnt <= wdt_cnt + 24'd1;
  end
`else
  logic wdt_unused;
  assign wdt_unused = wdt_kick ^ (^WDT_TIMEOUT);
  assign wdt_evt    = 1'b0;
`endif

  assign evt       = sw_rst_req | ext_rst_req | wdt_evt;
  assign cause_now = {wdt_evt, ext_rst_req, sw_rst_req};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    dom_nxt   = domain_rst_n;
    case (state)
      HOLD: begin
        dom_nxt = '0;
        idx_nxt = '0;
        if (evt)
          cnt_nxt = '0;
        else if (cnt >= HOLD_LAST) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
          dom_nxt   = NUM_DOMAINS'(1);
        end else
          cnt_nxt = cnt + 8'd1;
      end
      RELEASE: begin
        if (evt) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          dom_nxt   = '0;
        end else if (idx == IDX_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt >= STAG_LAST) begin
          // Released bits are contiguous from bit 0, so shifting in a 1 frees the next domain.
          cnt_nxt = '0;
          idx_nxt = idx + 3'd1;
          dom_nxt = NUM_DOMAINS'({domain_rst_n, 1'b1});
        end else
          cnt_nxt = cnt + 8'd1;
      end
      RUN: begin
        if (evt) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          dom_nxt   = '0;
        end
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
        idx_nxt   = '0;
        dom_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HOLD;
      cnt          <= '0;
      idx          <= '0;
      domain_rst_n <= '0;
      all_released <= 1'b0;
      rst_cause    <= 3'b000;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      domain_rst_n <= dom_nxt;
      all_released <= (state_nxt == RUN);
      if (evt)
        rst_cause <= cause_now;
      else if (cause_clear)
        rst_cause <= 3'b000;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (4 domains, hold 16, stagger 8).
// Watchdog scenario follows RST_SEQ_WDT_EN.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst, sw, ext, kick, clr;
  logic [3:0] dom;
  logic       allr;
  logic [2:0] cause;
  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_DOMAINS(4), .HOLD_CYCLES(16), .STAGGER_CYCLES(8), .WDT_TIMEOUT(24'd100)
  ) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw), .ext_rst_req(ext), .wdt_kick(kick),
    .cause_clear(clr), .domain_rst_n(dom), .all_released(allr), .rst_cause(cause)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected {all_released, domain_rst_n} e edges after the hold count restarts from 0.
  function automatic logic [4:0] exp_seq(int e);
    if (e < 16) return 5'b0_0000;
    if (e < 24) return 5'b0_0001;
    if (e < 32) return 5'b0_0011;
    if (e < 40) return 5'b0_0111;
    if (e < 41) return 5'b0_1111;
    return 5'b1_1111;
  endfunction

  task automatic test_reset;
    rst = 1'b1; sw = 1'b0; ext = 1'b0; kick = 1'b0; clr = 1'b0;
    repeat (3) step();
    checks++;
    if ({allr, dom} !== 5'b0_0000) begin
      errors++; $display("FAIL reset_outputs got %b exp %b", {allr, dom}, 5'b0_0000);
    end
    checks++;
    if (cause !== 3'b000) begin
      errors++; $display("FAIL reset_cause got %b exp %b", cause, 3'b000);
    end
    rst = 1'b0;
  endtask

  task automatic test_power_on;
    for (int e = 1; e <= 41; e++) begin
      step();
      if (e == 15 || e == 16 || e == 24 || e == 31 || e == 32 || e == 40 || e == 41) begin
        checks++;
        if ({allr, dom} !== exp_seq(e)) begin
          errors++; $display("FAIL power_on_e%0d got %b exp %b", e, {allr, dom}, exp_seq(e));
        end
      end
    end
    checks++;
    if (cause !== 3'b000) begin
      errors++; $display("FAIL power_on_cause got %b exp %b", cause, 3'b000);
    end
  endtask

  task automatic test_sw_reset;
    sw = 1'b1; step(); sw = 1'b0;
    checks++;
    if ({allr, dom} !== 5'b0_0000) begin
      errors++; $display("FAIL sw_immediate got %b exp %b", {allr, dom}, 5'b0_0000);
    end
    checks++;
    if (cause !== 3'b001) begin
      errors++; $display("FAIL sw_cause got %b exp %b", cause, 3'b001);
    end
    for (int e = 1; e <= 41; e++) begin
      step();
      if (e == 15 || e == 16 || e == 24 || e == 32 || e == 39 || e == 40 || e == 41) begin
        checks++;
        if ({allr, dom} !== exp_seq(e)) begin
          errors++; $display("FAIL sw_seq_e%0d got %b exp %b", e, {allr, dom}, exp_seq(e));
        end
      end
    end
  endtask

  task automatic test_ext_reset;
    int bad = 0;
    ext = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if ({allr, dom} !== 5'b0_0000) bad++;
    end
    ext = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL ext_hold_zero got %0d nonzero cycles exp 0", bad);
    end
    checks++;
    if (cause !== 3'b010) begin
      errors++; $display("FAIL ext_cause got %b exp %b", cause, 3'b010);
    end
    for (int e = 1; e <= 41; e++) begin
      step();
      if (e == 15 || e == 16 || e == 41) begin
        checks++;
        if ({allr, dom} !== exp_seq(e)) begin
          errors++; $display("FAIL ext_seq_e%0d got %b exp %b", e, {allr, dom}, exp_seq(e));
        end
      end
    end
  endtask

  task automatic test_sw_mid_release;
    sw = 1'b1; step(); sw = 1'b0;
    repeat (32) step();
    checks++;
    if ({allr, dom} !== 5'b0_0111) begin
      errors++; $display("FAIL mid_before got %b exp %b", {allr, dom}, 5'b0_0111);
    end
    sw = 1'b1; step(); sw = 1'b0;
    checks++;
    if ({allr, dom} !== 5'b0_0000) begin
      errors++; $display("FAIL mid_cleared got %b exp %b", {allr, dom}, 5'b0_0000);
    end
    for (int e = 1; e <= 41; e++) begin
      step();
      if (e == 15 || e == 16 || e == 41) begin
        checks++;
        if ({allr, dom} !== exp_seq(e)) begin
          errors++; $display("FAIL mid_seq_e%0d got %b exp %b", e, {allr, dom}, exp_seq(e));
        end
      end
    end
  endtask

  task automatic test_hold_restart;
    sw = 1'b1; step(); sw = 1'b0;
    repeat (10) step();
    sw = 1'b1; step(); sw = 1'b0;
    for (int e = 1; e <= 41; e++) begin
      step();
      if (e == 15 || e == 16 || e == 41) begin
        checks++;
        if ({allr, dom} !== exp_seq(e)) begin
          errors++; $display("FAIL hold_restart_e%0d got %b exp %b", e, {allr, dom}, exp_seq(e));
        end
      end
    end
  endtask

  task automatic test_cause_combo;
    sw = 1'b1; ext = 1'b1; clr = 1'b1;
    step();
    sw = 1'b0; ext = 1'b0; clr = 1'b0;
    checks++;
    if (cause !== 3'b011) begin
      errors++; $display("FAIL combo_cause got %b exp %b", cause, 3'b011);
    end
    repeat (41) step();
    checks++;
    if ({allr, dom} !== 5'b1_1111) begin
      errors++; $display("FAIL combo_run got %b exp %b", {allr, dom}, 5'b1_1111);
    end
    clr = 1'b1; step(); clr = 1'b0;
    checks++;
    if (cause !== 3'b000) begin
      errors++; $display("FAIL cause_clear got %b exp %b", cause, 3'b000);
    end
  endtask

  task automatic test_rst_override;
    sw = 1'b1; step(); sw = 1'b0;
    repeat (20) step();
    rst = 1'b1; sw = 1'b1; ext = 1'b1;
    step();
    checks++;
    if ({cause, allr, dom} !== 8'b000_0_0000) begin
      errors++; $display("FAIL rst_override got %b exp %b", {cause, allr, dom}, 8'b000_0_0000);
    end
    rst = 1'b0; sw = 1'b0; ext = 1'b0;
    for (int e = 1; e <= 41; e++) begin
      step();
      if (e == 16 || e == 41) begin
        checks++;
        if ({allr, dom} !== exp_seq(e)) begin
          errors++; $display("FAIL rst_seq_e%0d got %b exp %b", e, {allr, dom}, exp_seq(e));
        end
      end
    end
  endtask

  task automatic test_watchdog;
    int bad = 0;
`ifdef RST_SEQ_WDT_EN
    sw = 1'b1; step(); sw = 1'b0;
    repeat (41) step();
    repeat (99) step();
    checks++;
    if ({allr, dom} !== 5'b1_1111) begin
      errors++; $display("FAIL wdt_before got %b exp %b", {allr, dom}, 5'b1_1111);
    end
    step();
    checks++;
    if ({allr, dom} !== 5'b0_0000) begin
      errors++; $display("FAIL wdt_expire got %b exp %b", {allr, dom}, 5'b0_0000);
    end
    checks++;
    if (cause !== 3'b100) begin
      errors++; $display("FAIL wdt_cause got %b exp %b", cause, 3'b100);
    end
    repeat (41) step();
    for (int i = 1; i <= 1000; i++) begin
      kick = (i % 50 == 0);
      step();
      if (allr !== 1'b1) bad++;
    end
    kick = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wdt_kicked got %0d reset cycles exp 0", bad);
    end
`else
    for (int i = 1; i <= 300; i++) begin
      kick = (i % 97 == 0);
      step();
      if (allr !== 1'b1) bad++;
    end
    kick = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL no_wdt_run got %0d reset cycles exp 0", bad);
    end
    checks++;
    if (cause[2] !== 1'b0) begin
      errors++; $display("FAIL no_wdt_cause2 got %b exp 0", cause[2]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_sw_reset();
    test_ext_reset();
    test_sw_mid_release();
    test_hold_restart();
    test_cause_combo();
    test_rst_override();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
